spi_frame_master: RTL and testbench

//  Parameterised SPI master. Shifts out one frame {rw, address, data} and captures MISO.

---
 rtl/spi_frame_master.sv | 209 ++++++++++++++++++++
 tb/tb_spi_frame_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// SPI master that shifts {rw, address, data} frames, single or burst, in all four CPOL/CPHA modes.
// Optional build macro SPI_MASTER_LSB_FIRST_EN sends and reassembles each field LSB first.
module spi_frame_master #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 15
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [DATA_WIDTH-1:0]                 data,
    input  logic [ADDRESS_WIDTH-1:0]              address,
    input  logic                                  read_write,
    input  logic                                  enable,
    input  logic                                  burst_enable,
    input  logic [15:0]                           burst_count,
    input  logic [15:0]                           divider,
    input  logic                                  clock_phase,
    input  logic                                  clock_polarity,
    input  logic                                  master_in_slave_out,
    output logic                                  serial_clock,
    output logic [DATA_WIDTH-1:0]                 read_data,
    output logic                                  busy,
    output logic                                  slave_select,
    output logic                                  master_out_slave_in,
    output logic [ADDRESS_WIDTH+DATA_WIDTH:0]     read_long_data,
    output logic                                  burst_data_valid,
    output logic                                  burst_data_ready
);

    localparam int FRAME_WIDTH = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int COUNT_WIDTH = $clog2(FRAME_WIDTH + 1);
    localparam logic [COUNT_WIDTH-1:0] FRAME_LAST = COUNT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COUNT_WIDTH-1:0] WORD_LAST  = COUNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

    function automatic logic [DATA_WIDTH-1:0] order_data(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < DATA_WIDTH; i++) r[i] = w[DATA_WIDTH-1-i];
`else
        r = w;
`endif
        return r;
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] order_address(input logic [ADDRESS_WIDTH-1:0] a);
        logic [ADDRESS_WIDTH-1:0] r;
`ifdef SPI_MASTER_LSB_FIRST_EN
        for (int i = 0; i < ADDRESS_WIDTH; i++) r[i] = a[ADDRESS_WIDTH-1-i];
`else
        r = a;
`endif
        return r;
    endfunction

    state_t                   state;
    logic [15:0]              div_q;
    logic [15:0]              div_cnt;
    logic                     cpha_q;
    logic                     cpol_q;
    logic                     rw_q;
    logic                     burst_q;
    logic [15:0]              words_left;
    logic                     seg_first;
    logic [COUNT_WIDTH-1:0]   bit_cnt;
    logic [FRAME_WIDTH-1:0]   tx_shift;
    logic [FRAME_WIDTH-1:0]   rx_shift;

    logic [FRAME_WIDTH-1:0]   frame;
    logic [FRAME_WIDTH-1:0]   rx_next;
    logic [FRAME_WIDTH-1:0]   rx_word;
    logic [DATA_WIDTH-1:0]    next_word;
    logic                     half_done;
    logic                     leading;
    logic                     seg_end;
    logic                     last_word;

    assign frame     = {read_write, order_address(address), order_data(data)};
    assign rx_next   = {rx_shift[FRAME_WIDTH-2:0], master_in_slave_out};
    // With CPHA=1 the final bit is sampled on the same edge that ends the word.
    assign rx_word   = cpha_q ? rx_next : rx_shift;
    assign next_word = rw_q ? '0 : order_data(data);
    assign half_done = (div_cnt == div_q);
    assign leading   = (serial_clock == cpol_q);
    assign seg_end   = seg_first ? (bit_cnt == FRAME_LAST) : (bit_cnt == WORD_LAST);
    assign last_word = (words_left == 16'd1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state               <= IDLE;
            busy                <= 1'b0;
            slave_select        <= 1'b1;
            master_out_slave_in <= 1'b0;
            serial_clock        <= clock_polarity;
            read_data           <= '0;
            read_long_data      <= '0;
            burst_data_valid    <= 1'b0;
            burst_data_ready    <= 1'b0;
            div_q               <= '0;
            div_cnt             <= '0;
            cpha_q              <= 1'b0;
            cpol_q              <= 1'b0;
            rw_q                <= 1'b0;
            burst_q             <= 1'b0;
            words_left          <= 16'd1;
            seg_first           <= 1'b1;
            bit_cnt             <= '0;
        end else begin
            burst_data_valid <= 1'b0;
            burst_data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    busy                <= 1'b0;
                    slave_select        <= 1'b1;
                    master_out_slave_in <= 1'b0;
                    serial_clock        <= clock_polarity;
                    if (enable) begin
                        state               <= SETUP;
                        busy                <= 1'b1;
                        slave_select        <= 1'b0;
                        div_q               <= divider;
                        div_cnt             <= '0;
                        cpha_q              <= clock_phase;
                        cpol_q              <= clock_polarity;
                        rw_q                <= read_write;
                        burst_q             <= burst_enable;
                        words_left          <= (burst_enable && burst_count != 16'd0) ? burst_count : 16'd1;
                        seg_first           <= 1'b1;
                        bit_cnt             <= '0;
                        master_out_slave_in <= frame[FRAME_WIDTH-1];
                        // CPHA=0 presents bit 0 now; CPHA=1 presents it on the first leading edge.
                        tx_shift            <= clock_phase ? frame : (frame << 1);
                        burst_data_ready    <= burst_enable & ~read_write;
                    end
                end
                SETUP: begin
                    if (half_done) begin
                        state   <= TRANSFER;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                TRANSFER: begin
                    if (!half_done) begin
                        div_cnt <= div_cnt + 16'd1;
                    end else begin
                        div_cnt      <= '0;
                        serial_clock <= ~serial_clock;
                        if (leading) begin
                            if (!cpha_q) begin
                                rx_shift <= rx_next;
                            end else begin
                                master_out_slave_in <= tx_shift[FRAME_WIDTH-1];
                                tx_shift            <= tx_shift << 1;
                            end
                        end else begin
                            if (cpha_q) rx_shift <= rx_next;
                            if (seg_end) begin
                                if (burst_q && rw_q) begin
                                    read_data        <= order_data(rx_word[DATA_WIDTH-1:0]);
                                    burst_data_valid <= 1'b1;
                                end
                                if (last_word) begin
                                    state        <= HOLD;
                                    slave_select <= 1'b1;
                                    if (!burst_q) begin
                                        read_data      <= order_data(rx_word[DATA_WIDTH-1:0]);
                                        read_long_data <= rx_word;
                                    end
                                end else begin
                                    // Next burst word follows the previous one with no gap.
                                    words_left       <= words_left - 16'd1;
                                    bit_cnt          <= '0;
                                    seg_first        <= 1'b0;
                                    burst_data_ready <= ~rw_q;
                                    if (cpha_q) begin
                                        tx_shift <= {next_word, {(FRAME_WIDTH-DATA_WIDTH){1'b0}}};
                                    end else begin
                                        master_out_slave_in <= next_word[DATA_WIDTH-1];
                                        tx_shift <= {next_word[DATA_WIDTH-2:0], {(FRAME_WIDTH-DATA_WIDTH+1){1'b0}}};
                                    end
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                if (!cpha_q) begin
                                    master_out_slave_in <= tx_shift[FRAME_WIDTH-1];
                                    tx_shift            <= tx_shift << 1;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    serial_clock <= cpol_q;
                    if (half_done) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: a slave model drives MISO and checks MOSI, a monitor checks results.
module tb_spi_frame_master;

    localparam int DW = 16;
    localparam int AW = 15;
    localparam int FW = 1 + AW + DW;
    localparam int HW = 1 + AW;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_n, enable, read_write, burst_enable, clock_phase, clock_polarity;
    logic          miso = 1'b0;
    logic [DW-1:0] data;
    logic [AW-1:0] address;
    logic [15:0]   burst_count, divider;
    logic          serial_clock, busy, slave_select, mosi, burst_data_valid, burst_data_ready;
    logic [DW-1:0] read_data;
    logic [FW-1:0] read_long_data;

    logic [DW-1:0] wr_arr [0:7];
    int            widx = 0;
    assign data = wr_arr[widx];

    spi_frame_master #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n), .data(data), .address(address),
        .read_write(read_write), .enable(enable), .burst_enable(burst_enable),
        .burst_count(burst_count), .divider(divider), .clock_phase(clock_phase),
        .clock_polarity(clock_polarity), .master_in_slave_out(miso),
        .serial_clock(serial_clock), .read_data(read_data), .busy(busy),
        .slave_select(slave_select), .master_out_slave_in(mosi),
        .read_long_data(read_long_data), .burst_data_valid(burst_data_valid),
        .burst_data_ready(burst_data_ready)
    );

    typedef struct {
        logic [DW-1:0] rd;
        logic [FW-1:0] rl;
        int            bits;
        int            edges;
        int            readies;
        int            valids;
        int            div;
        logic          cpha;
        logic          cpol;
    } exp_t;

    exp_t          exp_q [$];
    int            mosi_q [$];
    bit            miso_q [$];
    logic [DW-1:0] word_q [$];

    int n_cmp = 0;
    int n_bad = 0;
    bit sb_off = 1'b1;

    logic [DW-1:0] tx_words [0:7];
    logic [DW-1:0] rx_words [0:7];
    logic [DW-1:0] model_rd = '0;
    logic [FW-1:0] model_rl = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Slave model and result monitor.
    logic p_sclk = 1'b0, p_busy = 1'b0, leading;
    int   since_edge = 0, edges = 0, readies = 0, valids = 0, sent = 0, e;
    bit   have_cur = 1'b0;
    exp_t cur;

    task automatic drive_miso();
        if (sent < cur.bits && miso_q.size() > 0) begin
            miso = miso_q.pop_front();
            sent++;
        end
    endtask

    always @(negedge clock) begin
        if (sb_off || !reset_n) begin
            have_cur = 1'b0;
            miso     = 1'b0;
            widx     = 0;
        end else begin
            since_edge++;
            if (busy && !p_busy) begin
                edges = 0; readies = 0; valids = 0; sent = 0; widx = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q[0];
                    have_cur = 1'b1;
                    check("ss_low_at_start", slave_select, 0);
                    if (!cur.cpha) drive_miso();
                end
            end
            if (burst_data_ready) begin
                readies++;
                if (widx < 7) widx++;
            end
            if (have_cur && busy && serial_clock != p_sclk) begin
                edges++;
                if (edges > 1) check("half_period", since_edge, cur.div + 1);
                since_edge = 0;
                if (edges < cur.edges) check("ss_low", slave_select, 0);
                leading = (p_sclk == cur.cpol);
                if (leading != cur.cpha) begin
                    if (mosi_q.size() > 0) begin
                        e = mosi_q.pop_front();
                        if (e >= 0) check("mosi_bit", mosi, e);
                    end else begin
                        check("mosi_extra_bit", 1, 0);
                    end
                end else begin
                    drive_miso();
                end
            end
            if (burst_data_valid) begin
                valids++;
                if (word_q.size() > 0) check("burst_word", read_data, word_q.pop_front());
                else check("unexpected_valid", 1, 0);
            end
            if (!busy && p_busy && have_cur) begin
                void'(exp_q.pop_front());
                check("sclk_edges", edges, cur.edges);
                check("hold_length", since_edge, cur.div + 1);
                check("ready_pulses", readies, cur.readies);
                check("valid_pulses", valids, cur.valids);
                check("read_data", read_data, cur.rd);
                check("read_long_data", read_long_data, cur.rl);
                check("sclk_idle", serial_clock, cur.cpol);
                check("ss_idle", slave_select, 1);
                have_cur = 1'b0;
                widx     = 0;
            end
        end
        p_sclk = serial_clock;
        p_busy = busy;
    end

    task automatic wait_busy(input logic lvl, input int budget, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clock); #1;
            if (busy === lvl) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy stayed %b, required %b within %0d clocks", nm, busy, lvl, budget);
        end
    endtask

    task automatic run_txn(input logic rw, input logic [AW-1:0] addr, input logic burst,
                           input logic [15:0] cnt, input logic [15:0] div,
                           input logic cpha, input logic cpol, input bit b2b);
        int            n;
        int            reps;
        logic [HW-1:0] hdr;
        exp_t          x;
        n    = (burst && cnt != 0) ? int'(cnt) : 1;
        reps = b2b ? 2 : 1;
        wait_busy(1'b0, 2000, "idle_before_start");
        read_write = rw; address = addr; burst_enable = burst; burst_count = cnt;
        divider = div; clock_phase = cpha; clock_polarity = cpol;
        for (int k = 0; k < 8; k++) wr_arr[k] = tx_words[k];
        for (int r = 0; r < reps; r++) begin
            hdr = 16'($urandom);
            mosi_q.push_back(int'(rw));
            for (int b = AW - 1; b >= 0; b--) mosi_q.push_back(int'(addr[b]));
            for (int k = 0; k < n; k++)
                for (int b = DW - 1; b >= 0; b--)
                    mosi_q.push_back((burst && rw) ? -1 : int'(tx_words[k][b]));
            for (int b = HW - 1; b >= 0; b--) miso_q.push_back(hdr[b]);
            for (int k = 0; k < n; k++)
                for (int b = DW - 1; b >= 0; b--) miso_q.push_back(rx_words[k][b]);
            if (!burst) begin
                model_rd = rx_words[0];
                model_rl = {hdr, rx_words[0]};
            end else if (rw) begin
                for (int k = 0; k < n; k++) word_q.push_back(rx_words[k]);
                model_rd = rx_words[n-1];
            end
            x.rd = model_rd; x.rl = model_rl;
            x.bits = HW + n * DW; x.edges = 2 * x.bits;
            x.readies = (burst && !rw) ? n : 0;
            x.valids  = (burst && rw) ? n : 0;
            x.div = int'(div); x.cpha = cpha; x.cpol = cpol;
            exp_q.push_back(x);
        end
        @(posedge clock); #1;
        enable = 1'b1;
        wait_busy(1'b1, 4, "busy_rise");
        if (b2b) begin
            wait_busy(1'b0, (2 * (HW + n * DW) + 6) * (int'(div) + 1) + 20, "first_frame_end");
            wait_busy(1'b1, 4, "back_to_back_rise");
        end
        enable = 1'b0;
        address = 15'($urandom); read_write = 1'($urandom); burst_enable = 1'($urandom);
        burst_count = 16'($urandom); divider = 16'($urandom);
        clock_phase = 1'($urandom); clock_polarity = 1'($urandom);
        wait_busy(1'b0, (2 * (HW + n * DW) + 6) * (int'(div) + 1) + 20, "frame_end");
    endtask

    task automatic rand_words();
        for (int k = 0; k < 8; k++) begin
            tx_words[k] = 16'($urandom);
            rx_words[k] = 16'($urandom);
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; read_write = 1'b0; burst_enable = 1'b0;
        clock_phase = 1'b0; clock_polarity = 1'b0; address = '0;
        burst_count = '0; divider = '0;
        for (int k = 0; k < 8; k++) wr_arr[k] = '0;
        repeat (3) @(posedge clock); #1;
        check("reset_busy", busy, 0);
        check("reset_ss", slave_select, 1);
        check("reset_mosi", mosi, 0);
        check("reset_sclk_cpol0", serial_clock, 0);
        check("reset_read_data", read_data, 0);
        check("reset_read_long", read_long_data, 0);
        check("reset_valid_ready", {burst_data_valid, burst_data_ready}, 0);
        clock_polarity = 1'b1;
        @(posedge clock); #1;
        check("reset_sclk_cpol1", serial_clock, 1);
        reset_n = 1'b1;
        @(posedge clock); #1;
        sb_off = 1'b0;

        rand_words(); tx_words[0] = 16'hA5C3;
        run_txn(1'b0, 15'h1111, 1'b0, 16'd0, 16'd3, 1'b0, 1'b0, 1'b0);
        rand_words(); rx_words[0] = 16'hBEEF;
        run_txn(1'b1, 15'h2A5A, 1'b0, 16'd0, 16'd1, 1'b0, 1'b0, 1'b0);
        rand_words(); rx_words[0] = 16'hBEEF;
        run_txn(1'b1, 15'h0123, 1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b0);
        rand_words(); rx_words[0] = 16'd1; rx_words[1] = 16'd2; rx_words[2] = 16'd3;
        run_txn(1'b1, 15'h7F00, 1'b1, 16'd3, 16'd1, 1'b0, 1'b1, 1'b0);
        rand_words();
        run_txn(1'b0, 15'h0F0F, 1'b1, 16'd2, 16'd2, 1'b1, 1'b0, 1'b0);
        rand_words();
        run_txn(1'b0, 15'h5555, 1'b1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        rand_words();
        run_txn(1'b1, 15'h3C3C, 1'b0, 16'd0, 16'd1, 1'b1, 1'b0, 1'b1);

        for (int t = 0; t < 25; t++) begin
            rand_words();
            run_txn(1'($urandom), 15'($urandom), ($urandom_range(0, 2) == 0),
                    16'($urandom_range(0, 4)), 16'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
        end

        // Abort a frame around bit 10 with reset, then run a clean frame.
        wait_busy(1'b0, 2000, "idle_before_abort");
        repeat (2) @(posedge clock); #1;
        sb_off = 1'b1;
        read_write = 1'b0; address = 15'h1234; burst_enable = 1'b0;
        divider = 16'd1; clock_phase = 1'b0; clock_polarity = 1'b1;
        @(posedge clock); #1;
        enable = 1'b1;
        wait_busy(1'b1, 4, "abort_busy_rise");
        enable = 1'b0;
        repeat (44) @(posedge clock); #1;
        check("busy_mid_frame", busy, 1);
        check("ss_mid_frame", slave_select, 0);
        reset_n = 1'b0;
        @(posedge clock); #1;
        check("abort_busy", busy, 0);
        check("abort_ss", slave_select, 1);
        check("abort_sclk", serial_clock, 1);
        check("abort_mosi", mosi, 0);
        check("abort_read_data", read_data, 0);
        check("abort_read_long", read_long_data, 0);
        exp_q.delete(); mosi_q.delete(); miso_q.delete(); word_q.delete();
        model_rd = '0; model_rl = '0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        sb_off = 1'b0;
        rand_words(); rx_words[0] = 16'hC0DE;
        run_txn(1'b1, 15'h4321, 1'b0, 16'd0, 16'd1, 1'b0, 1'b1, 1'b0);

        repeat (4) @(posedge clock); #1;
        check("queues_drained", exp_q.size() + word_q.size() + mosi_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
